mux_4_1: RTL and testbench

MUX_4_1 -- requirements
Module: mux_4_1

---
 rtl/mux_4_1.sv | 55 +++++
 tb/tb_mux_4_1.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mux_4_1.sv
// mux_4_1: 4-to-1 multiplexer, select {s0,s1}, with an optional registered output
// that carries the captured channel index and a capture-valid flag.
module mux_4_1 #(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y_comb,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic [1:0]       sel_q
);
  logic [1:0] idx;
  assign idx = {s0, s1};
  always_comb y_comb = idx[1] ? (idx[0] ? d3 : d2) : (idx[0] ? d1 : d0);
  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       idx_q, idx_d;
    logic             vld_q, vld_d;
    // data and index hold while en is low; the valid flag only marks fresh captures
    always_comb begin
      y_d   = en ? y_comb : y_q;
      idx_d = en ? idx : idx_q;
      vld_d = en;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        y_q   <= '0;
        idx_q <= '0;
        vld_q <= 1'b0;
      end else begin
        y_q   <= y_d;
        idx_q <= idx_d;
        vld_q <= vld_d;
      end
    end
    assign y       = y_q;
    assign sel_q   = idx_q;
    assign y_valid = vld_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign y       = y_comb;
    assign sel_q   = idx;
    assign y_valid = en;
  end
endmodule

// File: tb/tb_mux_4_1.sv
// tb_mux_4_1: scoreboard bench over three mux_4_1 builds (1-bit registered,
// 8-bit registered, 8-bit combinational) driven from shared select/enable/reset.
module tb_mux_4_1;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, s0 = 1'b0, s1 = 1'b0;
  logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;
  logic [7:0] w0 = 8'h11, w1 = 8'h22, w2 = 8'h33, w3 = 8'h44;
  logic       ya_comb, ya, ya_v;
  logic [1:0] sa, sb, sc;
  logic [7:0] yb_comb, yb, yc_comb, yc;
  logic       yb_v, yc_v;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic       ya;
    logic [1:0] s;
    logic [7:0] yb;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  mux_4_1 #(.WIDTH(1), .REG_OUT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .s0(s0), .s1(s1),
    .d0(a0), .d1(a1), .d2(a2), .d3(a3),
    .y_comb(ya_comb), .y(ya), .y_valid(ya_v), .sel_q(sa));
  mux_4_1 #(.WIDTH(8), .REG_OUT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .s0(s0), .s1(s1),
    .d0(w0), .d1(w1), .d2(w2), .d3(w3),
    .y_comb(yb_comb), .y(yb), .y_valid(yb_v), .sel_q(sb));
  mux_4_1 #(.WIDTH(8), .REG_OUT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .s0(s0), .s1(s1),
    .d0(w0), .d1(w1), .d2(w2), .d3(w3),
    .y_comb(yc_comb), .y(yc), .y_valid(yc_v), .sel_q(sc));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // av = {d0,d1,d2,d3} for the 1-bit build; ea/eb are the hand-computed selections
  task automatic vec(input logic s0v, input logic s1v, input logic [3:0] av,
                     input logic ea, input logic [7:0] eb);
    exp_t e;
    @(negedge clk);
    en = 1'b1; s0 = s0v; s1 = s1v;
    {a0, a1, a2, a3} = av;
    e.ya = ea; e.s = {s0v, s1v}; e.yb = eb;
    q.push_back(e);
    #1;
    check("a_y_comb", 64'(ya_comb), 64'(ea));
    check("b_y_comb", 64'(yb_comb), 64'(eb));
    check("c_y", 64'(yc), 64'(eb));
    check("c_y_comb", 64'(yc_comb), 64'(eb));
    check("c_sel", 64'(sc), 64'({s0v, s1v}));
    check("c_valid", 64'(yc_v), 64'(1));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ya_v) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_valid: got y=%0h with empty scoreboard", ya);
        end else begin
          e = q.pop_front();
          check("a_y", 64'(ya), 64'(e.ya));
          check("a_sel", 64'(sa), 64'(e.s));
          check("b_y", 64'(yb), 64'(e.yb));
          check("b_sel", 64'(sb), 64'(e.s));
          check("b_valid", 64'(yb_v), 64'(1));
        end
      end
    end
  end

  initial begin : stim
    int t;
    en = 1'b1; s0 = 1'b1; s1 = 1'b1; {a0, a1, a2, a3} = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_y", 64'(ya), 64'(0));
    check("rst_a_sel", 64'(sa), 64'(0));
    check("rst_a_valid", 64'(ya_v), 64'(0));
    check("rst_b_y", 64'(yb), 64'(0));
    check("rst_a_y_comb", 64'(ya_comb), 64'(1));
    @(negedge clk);
    en = 1'b0; rst_n = 1'b1;
    vec(1'b0, 1'b0, 4'b1000, 1'b1, 8'h11);
    vec(1'b0, 1'b1, 4'b0100, 1'b1, 8'h22);
    vec(1'b1, 1'b0, 4'b0010, 1'b1, 8'h33);
    vec(1'b1, 1'b1, 4'b0001, 1'b1, 8'h44);
    vec(1'b0, 1'b0, 4'b0111, 1'b0, 8'h11);
    vec(1'b0, 1'b1, 4'b1011, 1'b0, 8'h22);
    vec(1'b1, 1'b0, 4'b1101, 1'b0, 8'h33);
    vec(1'b1, 1'b1, 4'b1110, 1'b0, 8'h44);
    vec(1'b1, 1'b0, 4'b0010, 1'b1, 8'h33);
    @(negedge clk);
    en = 1'b0; a2 = 1'b0;
    #1;
    check("c_valid_en0", 64'(yc_v), 64'(0));
    @(negedge clk);
    check("hold_a_y", 64'(ya), 64'(1));
    check("hold_a_sel", 64'(sa), 64'(2));
    check("hold_a_valid", 64'(ya_v), 64'(0));
    check("hold_b_y", 64'(yb), 64'(8'h33));
    check("hold_a_y_comb", 64'(ya_comb), 64'(0));
    a2 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_a_y", 64'(ya), 64'(0));
    check("arst_a_sel", 64'(sa), 64'(0));
    check("arst_a_valid", 64'(ya_v), 64'(0));
    check("arst_b_y", 64'(yb), 64'(0));
    check("arst_a_y_comb", 64'(ya_comb), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_a_y", 64'(ya), 64'(0));
    check("post_rst_a_valid", 64'(ya_v), 64'(0));
    vec(1'b1, 1'b1, 4'b0001, 1'b1, 8'h44);
    @(negedge clk);
    en = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
